// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RISC-V width codes,
// FSM state encoding and the byte-enable helper.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // Access size comes from func3[1:0]; the mask is positioned at the byte offset.
    function automatic logic [7:0] mk_be(input logic [2:0] func3, input logic [2:0] offset);
        logic [7:0] base;
        case (func3[1:0])
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/stage_mem_lsu_align.sv
// Combinational lane logic: store replication and byte enables, load shift and
// extension, and misaligned/illegal-width detection.
module stage_mem_lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        func3,
    input  logic              is_store,
    input  logic [2:0]        offset,
    input  logic [XLEN-1:0]   store_data,
    input  logic [2:0]        ld_func3,
    input  logic [2:0]        ld_offset,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned,
    output logic              illegal
);

    localparam int NBYTES = XLEN / 8;
    localparam bit IS64   = (XLEN == 64);

    logic [7:0]      be_full_s;
    logic [XLEN-1:0] shifted_s;

    assign be_full_s = mk_be(func3, offset);
    assign be        = be_full_s[NBYTES-1:0];
    assign shifted_s = rdata >> {ld_offset, 3'b000};

    // Replicate the store operand across every lane of its size.
    always_comb begin
        wdata = store_data;
        case (func3[1:0])
            2'b00:   wdata = {NBYTES{store_data[7:0]}};
            2'b01:   wdata = {(NBYTES/2){store_data[15:0]}};
            2'b10:   wdata = {(NBYTES/4){store_data[31:0]}};
            default: wdata = store_data;
        endcase
    end

    // Natural alignment check plus width legality for the configured XLEN.
    always_comb begin
        misaligned = 1'b0;
        case (func3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = |offset[1:0];
            default: misaligned = |offset;
        endcase
        illegal = 1'b0;
        if (func3 == 3'b111) begin
            illegal = 1'b1;
        end else if (!IS64 && ((func3 == LD) || (func3 == LWU))) begin
            illegal = 1'b1;
        end else if (is_store) begin
            illegal = !((func3 == SB) || (func3 == SH) || (func3 == SW) ||
                        ((func3 == SD) && IS64));
        end else begin
            illegal = 1'b0;
        end
    end

    // Extract the addressed element and sign- or zero-extend it.
    always_comb begin
        load_data = shifted_s;
        case (ld_func3)
            LB:      load_data = XLEN'($signed(shifted_s[7:0]));
            LH:      load_data = XLEN'($signed(shifted_s[15:0]));
            LW:      load_data = XLEN'($signed(shifted_s[31:0]));
            LD:      load_data = shifted_s;
            LBU:     load_data = XLEN'(shifted_s[7:0]);
            LHU:     load_data = XLEN'(shifted_s[15:0]);
            LWU:     load_data = XLEN'(shifted_s[31:0]);
            default: load_data = shifted_s;
        endcase
    end

endmodule

// File: rtl/stage_mem_lsu.sv
// MEM-stage load/store unit: issues one access per instruction over a
// req/gnt/rvalid memory port and stalls the pipeline until it completes.
module stage_mem_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              me_valid,
    input  logic              me_mem_read,
    input  logic              me_mem_write,
    input  logic [2:0]        me_func3_code,
    input  logic [ADDR_W-1:0] me_alu_o,
    input  logic [XLEN-1:0]   me_regs_data2,
    input  logic              forward_data,
    input  logic [XLEN-1:0]   w_regs_data,
    output logic [XLEN-1:0]   me_mem_data,
    output logic              me_stall,
    output logic              me_lsu_fault,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata
);

    localparam int NBYTES = XLEN / 8;

    lsu_state_e        state_r;
    logic              req_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [NBYTES-1:0] be_r;
    logic [XLEN-1:0]   wdata_r;
    logic [2:0]        off_r;
    logic [2:0]        func3_r;
    logic [XLEN-1:0]   mem_data_r;

    logic              access_s;
    logic              fault_s;
    logic              misaligned_s;
    logic              illegal_s;
    logic [2:0]        off_s;
    logic [XLEN-1:0]   store_data_s;
    logic [NBYTES-1:0] be_s;
    logic [XLEN-1:0]   wdata_s;
    logic [XLEN-1:0]   load_s;
    logic              stall_s;
    logic              fault_out_s;

    assign access_s     = me_valid & (me_mem_read ^ me_mem_write);
    assign fault_s      = (access_s & (misaligned_s | illegal_s)) |
                          (me_valid & me_mem_read & me_mem_write);
    assign off_s        = me_alu_o[2:0] & 3'(NBYTES - 1);
    assign store_data_s = forward_data ? w_regs_data : me_regs_data2;

    stage_mem_lsu_align #(.XLEN(XLEN)) u_align (
        .func3      (me_func3_code),
        .is_store   (me_mem_write),
        .offset     (off_s),
        .store_data (store_data_s),
        .ld_func3   (func3_r),
        .ld_offset  (off_r),
        .rdata      (dmem_rdata),
        .be         (be_s),
        .wdata      (wdata_s),
        .load_data  (load_s),
        .misaligned (misaligned_s),
        .illegal    (illegal_s)
    );

    // Access sequencer: latch request fields, hold them through the handshake, capture loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            be_r       <= '0;
            wdata_r    <= '0;
            off_r      <= 3'd0;
            func3_r    <= 3'd0;
            mem_data_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (access_s && !fault_s) begin
                        state_r <= REQ;
                        req_r   <= 1'b1;
                        we_r    <= me_mem_write;
                        addr_r  <= me_alu_o & ~ADDR_W'(NBYTES - 1);
                        be_r    <= be_s;
                        wdata_r <= wdata_s;
                        off_r   <= off_s;
                        func3_r <= me_func3_code;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        req_r   <= 1'b0;
                        state_r <= we_r ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        mem_data_r <= load_s;
                        state_r    <= DONE;
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Stall must rise in the same cycle an access is accepted, so it is decoded from state.
    always_comb begin
        stall_s     = 1'b0;
        fault_out_s = 1'b0;
        if (rst) begin
            stall_s     = 1'b0;
            fault_out_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    stall_s     = access_s & ~fault_s;
                    fault_out_s = fault_s;
                end
                REQ:     stall_s = 1'b1;
                WAIT:    stall_s = 1'b1;
                DONE:    stall_s = 1'b0;
                default: stall_s = 1'b0;
            endcase
        end
    end

    assign me_stall     = stall_s;
    assign me_lsu_fault = fault_out_s;
    assign me_mem_data  = mem_data_r;
    assign dmem_req     = req_r;
    assign dmem_we      = we_r;
    assign dmem_addr    = addr_r;
    assign dmem_be      = be_r;
    assign dmem_wdata   = wdata_r;

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Directed bench for stage_mem_lsu at XLEN=32 and XLEN=64 with a scripted
// variable-latency memory responder.
module tb_stage_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel64 = 1'b0;
    logic        me_valid = 1'b0;
    logic        me_mem_read = 1'b0;
    logic        me_mem_write = 1'b0;
    logic [2:0]  me_func3_code = 3'd0;
    logic [31:0] me_alu_o = 32'd0;
    logic [63:0] me_regs_data2 = 64'd0;
    logic        forward_data = 1'b0;
    logic [63:0] w_regs_data = 64'd0;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [63:0] dmem_rdata = 64'd0;

    logic        valid32, valid64;
    logic [31:0] md32, addr32, wd32;
    logic [63:0] md64, wd64;
    logic [31:0] addr64;
    logic [3:0]  be32;
    logic [7:0]  be64;
    logic        stall32, stall64, fault32, fault64, req32, req64, we32, we64;

    logic [63:0] obs_md, obs_wdata;
    logic [31:0] obs_addr;
    logic [7:0]  obs_be;
    logic        obs_stall, obs_fault, obs_req, obs_we;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign valid32   = me_valid & ~sel64;
    assign valid64   = me_valid & sel64;
    assign obs_md    = sel64 ? md64 : {32'd0, md32};
    assign obs_wdata = sel64 ? wd64 : {32'd0, wd32};
    assign obs_addr  = sel64 ? addr64 : addr32;
    assign obs_be    = sel64 ? be64 : {4'd0, be32};
    assign obs_stall = sel64 ? stall64 : stall32;
    assign obs_fault = sel64 ? fault64 : fault32;
    assign obs_req   = sel64 ? req64 : req32;
    assign obs_we    = sel64 ? we64 : we32;

    stage_mem_lsu #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst(rst), .me_valid(valid32), .me_mem_read(me_mem_read),
        .me_mem_write(me_mem_write), .me_func3_code(me_func3_code), .me_alu_o(me_alu_o),
        .me_regs_data2(me_regs_data2[31:0]), .forward_data(forward_data),
        .w_regs_data(w_regs_data[31:0]), .me_mem_data(md32), .me_stall(stall32),
        .me_lsu_fault(fault32), .dmem_req(req32), .dmem_we(we32), .dmem_addr(addr32),
        .dmem_be(be32), .dmem_wdata(wd32), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata[31:0])
    );

    stage_mem_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst), .me_valid(valid64), .me_mem_read(me_mem_read),
        .me_mem_write(me_mem_write), .me_func3_code(me_func3_code), .me_alu_o(me_alu_o),
        .me_regs_data2(me_regs_data2), .forward_data(forward_data),
        .w_regs_data(w_regs_data), .me_mem_data(md64), .me_stall(stall64),
        .me_lsu_fault(fault64), .dmem_req(req64), .dmem_we(we64), .dmem_addr(addr64),
        .dmem_be(be64), .dmem_wdata(wd64), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ":stall"}, 64'(obs_stall), 64'd0);
        chk({tag, ":fault"}, 64'(obs_fault), 64'd0);
        chk({tag, ":req"},   64'(obs_req),   64'd0);
        chk({tag, ":we"},    64'(obs_we),    64'd0);
        chk({tag, ":addr"},  64'(obs_addr),  64'd0);
        chk({tag, ":be"},    64'(obs_be),    64'd0);
        chk({tag, ":wdata"}, obs_wdata,      64'd0);
        chk({tag, ":mdata"}, obs_md,         64'd0);
    endtask

    // Called right after a rising edge with the DUT in IDLE; returns likewise.
    task automatic run(input string tag, input logic [2:0] f3, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [63:0] rs2, input logic fwd,
                       input logic [63:0] wv, input logic [63:0] rdata, input int gd,
                       input int rvd, input logic [31:0] e_addr, input logic [7:0] e_be,
                       input logic [63:0] e_wdata, input int e_stalls, input int e_reqs,
                       input int e_faults, input logic [63:0] e_md);
        int  stalls = 0, reqs = 0, faults = 0, req_cyc = 0, since_gnt = -1;
        bit  done = 1'b0, granted = 1'b0, prev_req = 1'b0;
        me_valid = 1'b1; me_mem_read = rd; me_mem_write = wr; me_func3_code = f3;
        me_alu_o = addr; me_regs_data2 = rs2; forward_data = fwd; w_regs_data = wv;
        for (int c = 0; c < 40 && !done; c++) begin
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (since_gnt >= 0) since_gnt++;
            if (obs_req && !granted) begin
                if (req_cyc == gd) dmem_gnt = 1'b1;
                req_cyc++;
            end
            if (since_gnt > 0 && since_gnt == rvd) begin
                dmem_rvalid = 1'b1; dmem_rdata = rdata;
            end
            @(negedge clk);
            if (obs_req && !prev_req) reqs++;
            prev_req = obs_req;
            if (obs_fault) faults++;
            if (obs_req) begin
                chk({tag, ":addr"},  64'(obs_addr), 64'(e_addr));
                chk({tag, ":be"},    64'(obs_be),   64'(e_be));
                chk({tag, ":wdata"}, obs_wdata,     e_wdata);
                chk({tag, ":we"},    64'(obs_we),   64'(wr));
            end
            if (obs_stall) stalls++; else done = 1'b1;
            if (dmem_gnt) begin granted = 1'b1; since_gnt = 0; end
            @(posedge clk); #1;
            if (c == 0) begin
                me_alu_o = addr ^ 32'hFFFF_FFF0; me_regs_data2 = ~rs2; w_regs_data = ~wv;
            end
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; me_valid = 1'b0;
        chk({tag, ":done"},   64'(done),   64'd1);
        chk({tag, ":stalls"}, 64'(stalls), 64'(e_stalls));
        chk({tag, ":reqs"},   64'(reqs),   64'(e_reqs));
        chk({tag, ":faults"}, 64'(faults), 64'(e_faults));
        @(negedge clk);
        chk({tag, ":mdata"},  obs_md, e_md);
        chk({tag, ":reqoff"}, 64'(obs_req), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("reset32");
        sel64 = 1'b1; #1;
        chk_idle_outputs("reset64");
        sel64 = 1'b0;
        @(posedge clk); #1;

        run("lb",   3'b000, 1'b1, 1'b0, 32'h1003, 64'd0, 1'b0, 64'd0, 64'h80AB_CDEF, 0, 1,
            32'h1000, 8'h08, 64'd0, 3, 1, 0, 64'hFFFF_FF80);
        run("lh",   3'b001, 1'b1, 1'b0, 32'h2000, 64'd0, 1'b0, 64'd0, 64'h0000_8001, 0, 1,
            32'h2000, 8'h03, 64'd0, 3, 1, 0, 64'hFFFF_8001);
        run("lhu",  3'b101, 1'b1, 1'b0, 32'h2000, 64'd0, 1'b0, 64'd0, 64'h0000_8001, 0, 1,
            32'h2000, 8'h03, 64'd0, 3, 1, 0, 64'h0000_8001);
        run("sb",   3'b000, 1'b0, 1'b1, 32'h1001, 64'h1111_1111, 1'b1, 64'h1234_56A5, 64'd0, 0, 1,
            32'h1000, 8'h02, 64'hA5A5_A5A5, 2, 1, 0, 64'h0000_8001);
        run("lwmis", 3'b010, 1'b1, 1'b0, 32'h0102, 64'd0, 1'b0, 64'd0, 64'd0, 0, 1,
            32'h0, 8'h0, 64'd0, 0, 0, 1, 64'h0000_8001);
        run("rdwr", 3'b010, 1'b1, 1'b1, 32'h0100, 64'd0, 1'b0, 64'd0, 64'd0, 0, 1,
            32'h0, 8'h0, 64'd0, 0, 0, 1, 64'h0000_8001);
        run("ld32", 3'b011, 1'b1, 1'b0, 32'h0000, 64'd0, 1'b0, 64'd0, 64'd0, 0, 1,
            32'h0, 8'h0, 64'd0, 0, 0, 1, 64'h0000_8001);
        run("sbad", 3'b100, 1'b0, 1'b1, 32'h0000, 64'd0, 1'b0, 64'd0, 64'd0, 0, 1,
            32'h0, 8'h0, 64'd0, 0, 0, 1, 64'h0000_8001);
        run("swslow", 3'b010, 1'b0, 1'b1, 32'h3004, 64'hCAFE_F00D, 1'b0, 64'd0, 64'd0, 3, 1,
            32'h3004, 8'h0F, 64'hCAFE_F00D, 5, 1, 0, 64'h0000_8001);
        run("lwslow", 3'b010, 1'b1, 1'b0, 32'h3008, 64'd0, 1'b0, 64'd0, 64'h8765_4321, 1, 4,
            32'h3008, 8'h0F, 64'd0, 7, 1, 0, 64'h8765_4321);

        // Reset while the load sits in WAIT; the late rvalid must be dropped.
        me_valid = 1'b1; me_mem_read = 1'b1; me_mem_write = 1'b0; me_func3_code = 3'b010;
        me_alu_o = 32'h4000; me_regs_data2 = 64'd0; forward_data = 1'b0;
        @(posedge clk); #1;
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk("rstw:req_in_req", 64'(obs_req), 64'd1);
        @(posedge clk); #1;
        dmem_gnt = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; me_valid = 1'b0; me_mem_read = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 64'hDEAD_BEEF;
        @(negedge clk);
        chk_idle_outputs("rstw");
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("rstw:late_mdata", obs_md, 64'd0);
        chk("rstw:late_stall", 64'(obs_stall), 64'd0);
        @(posedge clk); #1;

        sel64 = 1'b1;
        run("ld64", 3'b011, 1'b1, 1'b0, 32'h0008, 64'd0, 1'b0, 64'd0, 64'h0123_4567_89AB_CDEF,
            0, 1, 32'h0008, 8'hFF, 64'd0, 3, 1, 0, 64'h0123_4567_89AB_CDEF);
        run("lw64", 3'b010, 1'b1, 1'b0, 32'h0014, 64'd0, 1'b0, 64'd0, 64'h89AB_CDEF_0000_0000,
            0, 2, 32'h0010, 8'hF0, 64'd0, 4, 1, 0, 64'hFFFF_FFFF_89AB_CDEF);
        run("lwu64", 3'b110, 1'b1, 1'b0, 32'h0014, 64'd0, 1'b0, 64'd0, 64'h89AB_CDEF_0000_0000,
            0, 1, 32'h0010, 8'hF0, 64'd0, 3, 1, 0, 64'h0000_0000_89AB_CDEF);
        run("sw64", 3'b010, 1'b0, 1'b1, 32'h0014, 64'h0000_0000_CAFE_F00D, 1'b0, 64'd0, 64'd0,
            0, 1, 32'h0010, 8'hF0, 64'hCAFE_F00D_CAFE_F00D, 2, 1, 0, 64'h0000_0000_89AB_CDEF);
        run("ldmis64", 3'b011, 1'b1, 1'b0, 32'h0004, 64'd0, 1'b0, 64'd0, 64'd0,
            0, 1, 32'h0, 8'h0, 64'd0, 0, 0, 1, 64'h0000_0000_89AB_CDEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
